mem_port_master: RTL and testbench

// Initiator side of one shared-RAM port: converts a core's burst load/store commands into
// per-cycle RAM port strobes (write_en/read_en/addr/Data_in) and returns read data.
// One instance per core; each drives one port of the multicore shared data RAM.
// RAM contract: write commits at clk edge; read_en latches addr at edge, data valid next cycle.

---
 rtl/mem_port_master.sv | 124 ++++++++++++
 tb/tb_mem_port_master.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_master.sv
// Initiator side of one shared-RAM port: turns burst load/store commands into per-cycle
// RAM strobes and returns read data two cycles after each read issue.
module mem_port_master #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 9,
  parameter int DEPTH  = 32,
  parameter int LEN_W  = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              wdata_valid,
  output logic              wdata_ready,
  input  logic [DATA_W-1:0] wdata,
  output logic              rdata_valid,
  output logic [DATA_W-1:0] rdata,
  output logic              done,
  output logic              err,
  output logic              ram_write_en,
  output logic              ram_read_en,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  typedef enum logic [2:0] {IDLE, WR, RD, RD_DRAIN, DONE, ERR} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [LEN_W-1:0]  count_reg;
  logic              issue_d1_reg;

  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
    return (a == LAST_ADDR) ? '0 : a + ADDR_W'(1);
  endfunction

  assign cmd_ready   = (state_reg == IDLE);
  assign wdata_ready = (state_reg == WR);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg    <= IDLE;
      addr_reg     <= '0;
      count_reg    <= '0;
      issue_d1_reg <= 1'b0;
      rdata_valid  <= 1'b0;
      rdata        <= '0;
      done         <= 1'b0;
      err          <= 1'b0;
      ram_write_en <= 1'b0;
      ram_read_en  <= 1'b0;
      ram_addr     <= '0;
      ram_wdata    <= '0;
    end else begin
      ram_write_en <= 1'b0;
      ram_read_en  <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      // RAM returns data the cycle after an issue; one more register stage aligns rdata_valid.
      issue_d1_reg <= ram_read_en;
      rdata_valid  <= issue_d1_reg;
      if (issue_d1_reg) rdata <= ram_rdata;

      case (state_reg)
        IDLE: begin
          if (cmd_valid) begin
            count_reg <= cmd_len;
            if (cmd_addr > LAST_ADDR) begin
              state_reg <= ERR;
              err       <= 1'b1;
            end else if (cmd_write) begin
              state_reg <= WR;
              addr_reg  <= cmd_addr;
            end else begin
              state_reg   <= RD;
              ram_read_en <= 1'b1;
              ram_addr    <= cmd_addr;
              addr_reg    <= next_addr(cmd_addr);
            end
          end
        end
        WR: begin
          if (wdata_valid) begin
            ram_write_en <= 1'b1;
            ram_addr     <= addr_reg;
            ram_wdata    <= wdata;
            addr_reg     <= next_addr(addr_reg);
            if (count_reg == '0) begin
              state_reg <= DONE;
              done      <= 1'b1;
            end else begin
              count_reg <= count_reg - LEN_W'(1);
            end
          end
        end
        RD: begin
          // The first issue was launched on accept, so count_reg beats remain.
          if (count_reg == '0) begin
            state_reg <= RD_DRAIN;
          end else begin
            ram_read_en <= 1'b1;
            ram_addr    <= addr_reg;
            addr_reg    <= next_addr(addr_reg);
            count_reg   <= count_reg - LEN_W'(1);
          end
        end
        RD_DRAIN: begin
          state_reg <= DONE;
          done      <= 1'b1;
        end
        DONE:    state_reg <= IDLE;
        ERR:     state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_master.sv
// Directed bench for mem_port_master: a cycle-indexed expectation model plus a RAM model,
// checked on every falling edge, with literal checks on the logged RAM/read traffic.
module tb_mem_port_master;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 9;
  localparam int DEPTH  = 32;
  localparam int LEN_W  = 4;
  localparam int MAXC   = 4096;

  logic              clk, rstn;
  logic              cmd_valid, cmd_ready, cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [LEN_W-1:0]  cmd_len;
  logic              wdata_valid, wdata_ready;
  logic [DATA_W-1:0] wdata;
  logic              rdata_valid, done, err;
  logic [DATA_W-1:0] rdata;
  logic              ram_write_en, ram_read_en;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata, ram_rdata;

  mem_port_master #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
    .clk(clk), .rstn(rstn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
    .rdata_valid(rdata_valid), .rdata(rdata), .done(done), .err(err),
    .ram_write_en(ram_write_en), .ram_read_en(ram_read_en), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Shared RAM: write commits at the edge, read data valid the following cycle.
  logic [DATA_W-1:0] ram [DEPTH];
  initial begin
    for (int i = 0; i < DEPTH; i++) ram[i] = '0;
    ram_rdata = '0;
  end
  always @(posedge clk) begin
    if (ram_write_en && ram_addr < DEPTH) ram[ram_addr] <= ram_wdata;
    if (ram_read_en && ram_addr < DEPTH) ram_rdata <= ram[ram_addr];
  end

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  // Expected outputs per cycle, filled from command/beat handshakes.
  bit                e_busy [MAXC];
  bit                e_wrdy [MAXC];
  bit                e_we   [MAXC];
  bit                e_re   [MAXC];
  bit                e_rv   [MAXC];
  bit                e_done [MAXC];
  bit                e_err  [MAXC];
  logic [ADDR_W-1:0] e_addr [MAXC];
  logic [DATA_W-1:0] e_wdata[MAXC];
  logic [DATA_W-1:0] e_rdata[MAXC];
  logic [DATA_W-1:0] ref_mem[DEPTH];
  bit                wr_open = 0;
  int                wr_addr, wr_left;

  initial for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;

  always @(negedge clk) begin
    if (!rstn) begin
      for (int i = cyc; i < MAXC; i++) begin
        e_busy[i] = 0; e_wrdy[i] = 0; e_we[i] = 0; e_re[i] = 0;
        e_rv[i] = 0; e_done[i] = 0; e_err[i] = 0;
      end
      wr_open = 0;
      check("rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
      check("rst_outputs", {26'b0, wdata_ready, rdata_valid, done, err, ram_write_en, ram_read_en}, 32'd0);
      check("rst_data", {ram_addr, ram_wdata}, '0);
    end else begin
      check("cmd_ready", {31'b0, cmd_ready}, {31'b0, !e_busy[cyc]});
      check("wdata_ready", {31'b0, wdata_ready}, {31'b0, e_wrdy[cyc]});
      check("ram_write_en", {31'b0, ram_write_en}, {31'b0, e_we[cyc]});
      check("ram_read_en", {31'b0, ram_read_en}, {31'b0, e_re[cyc]});
      if (e_we[cyc] || e_re[cyc]) check("ram_addr", {23'b0, ram_addr}, {23'b0, e_addr[cyc]});
      if (e_we[cyc]) check("ram_wdata", {16'b0, ram_wdata}, {16'b0, e_wdata[cyc]});
      check("rdata_valid", {31'b0, rdata_valid}, {31'b0, e_rv[cyc]});
      if (e_rv[cyc]) check("rdata", {16'b0, rdata}, {16'b0, e_rdata[cyc]});
      check("done", {31'b0, done}, {31'b0, e_done[cyc]});
      check("err", {31'b0, err}, {31'b0, e_err[cyc]});

      if (cmd_valid && !e_busy[cyc]) begin
        if (cmd_addr >= DEPTH) begin
          e_busy[cyc+1] = 1;
          e_err[cyc+1]  = 1;
        end else if (cmd_write) begin
          wr_open = 1;
          wr_addr = int'(cmd_addr);
          wr_left = int'(cmd_len) + 1;
        end else begin
          for (int i = 0; i <= int'(cmd_len); i++) begin
            int a;
            a = (int'(cmd_addr) + i) % DEPTH;
            e_re[cyc+1+i]    = 1;
            e_addr[cyc+1+i]  = ADDR_W'(a);
            e_rv[cyc+3+i]    = 1;
            e_rdata[cyc+3+i] = ref_mem[a];
          end
          for (int i = cyc + 1; i <= cyc + 3 + int'(cmd_len); i++) e_busy[i] = 1;
          e_done[cyc+3+int'(cmd_len)] = 1;
        end
      end
      if (wdata_valid && e_wrdy[cyc]) begin
        e_we[cyc+1]    = 1;
        e_addr[cyc+1]  = ADDR_W'(wr_addr);
        e_wdata[cyc+1] = wdata;
        ref_mem[wr_addr] = wdata;
        wr_addr = (wr_addr + 1) % DEPTH;
        wr_left--;
        if (wr_left == 0) begin
          wr_open        = 0;
          e_busy[cyc+1]  = 1;
          e_done[cyc+1]  = 1;
        end
      end
      if (wr_open) begin
        e_busy[cyc+1] = 1;
        e_wrdy[cyc+1] = 1;
      end
    end
  end

  // Traffic log for the literal per-test expectations.
  logic [ADDR_W-1:0] wr_addr_q[$];
  logic [DATA_W-1:0] rd_q[$];
  int done_cnt, err_cnt, strobe_cnt;

  always @(negedge clk) begin
    if (rstn) begin
      if (ram_write_en) wr_addr_q.push_back(ram_addr);
      if (rdata_valid) rd_q.push_back(rdata);
      if (done) done_cnt++;
      if (err) err_cnt++;
      if (ram_write_en || ram_read_en) strobe_cnt++;
    end
  end

  task automatic clear_log();
    wr_addr_q.delete();
    rd_q.delete();
    done_cnt = 0;
    err_cnt = 0;
    strobe_cnt = 0;
  endtask

  // All driver tasks start and end at posedge + 1.
  task automatic send_cmd(input bit wr, input int addr, input int len, output int waited);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = ADDR_W'(addr);
    cmd_len   = LEN_W'(len);
    waited    = 0;
    forever begin
      @(negedge clk);
      if (cmd_ready) break;
      waited++;
      if (waited > 50) begin
        check("cmd_accept_timeout", 32'(waited), 32'd0);
        break;
      end
    end
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic send_beat(input logic [DATA_W-1:0] d, input int gap);
    int n;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    wdata_valid = 1'b1;
    wdata       = d;
    n = 0;
    forever begin
      @(negedge clk);
      if (wdata_ready) break;
      n++;
      if (n > 50) begin
        check("beat_accept_timeout", 32'(n), 32'd0);
        break;
      end
    end
    @(posedge clk);
    #1 wdata_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (cmd_ready) break;
      n++;
      if (n > 60) begin
        check("idle_timeout", 32'(n), 32'd0);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int lat;
    rstn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    wdata_valid = 1'b0; wdata = '0;
    clear_log();
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    repeat (2) @(posedge clk);

    // Reset while idle, then a command offered at release is taken on the next edge.
    #2 rstn = 1'b0;
    #1 check("t1_cmd_ready_in_rst", {31'b0, cmd_ready}, 32'd1);
    @(posedge clk);
    #1 rstn = 1'b1;

    // Single-beat write then read of address 5.
    send_cmd(1'b1, 5, 0, lat);
    check("t1_accept_latency", 32'(lat), 32'd0);
    send_beat(16'hBEEF, 0);
    wait_idle();
    check("t2_wr_count", 32'(wr_addr_q.size()), 32'd1);
    check("t2_wr_addr", {23'b0, wr_addr_q[0]}, 32'd5);
    check("t2_wr_done", 32'(done_cnt), 32'd1);
    clear_log();
    send_cmd(1'b0, 5, 0, lat);
    wait_idle();
    check("t2_rd_data", {16'b0, rd_q[0]}, 32'h0000BEEF);
    check("t2_rd_done", 32'(done_cnt), 32'd1);

    // Wrapping 4-beat write at 30 and read-back.
    clear_log();
    send_cmd(1'b1, 30, 3, lat);
    for (int i = 1; i <= 4; i++) send_beat(16'(i), 0);
    wait_idle();
    check("t3_wr_count", 32'(wr_addr_q.size()), 32'd4);
    check("t3_wr_addrs", {wr_addr_q[0][7:0], wr_addr_q[1][7:0], wr_addr_q[2][7:0], wr_addr_q[3][7:0]}, 32'h1E1F0001);
    clear_log();
    send_cmd(1'b0, 30, 3, lat);
    wait_idle();
    check("t3_rd_data", {rd_q[0][7:0], rd_q[1][7:0], rd_q[2][7:0], rd_q[3][7:0]}, 32'h01020304);

    // 3-beat write with two idle cycles between beats.
    clear_log();
    send_cmd(1'b1, 10, 2, lat);
    send_beat(16'h00A1, 0);
    send_beat(16'h00A2, 2);
    send_beat(16'h00A3, 2);
    wait_idle();
    check("t4_wr_count", 32'(wr_addr_q.size()), 32'd3);
    check("t4_wr_addrs", {8'd0, wr_addr_q[0][7:0], wr_addr_q[1][7:0], wr_addr_q[2][7:0]}, 32'h000A0B0C);
    check("t4_done_count", 32'(done_cnt), 32'd1);

    // Out-of-range start address.
    clear_log();
    send_cmd(1'b0, 40, 0, lat);
    wait_idle();
    check("t5_err_count", 32'(err_cnt), 32'd1);
    check("t5_strobes", 32'(strobe_cnt), 32'd0);

    // Reset in the middle of a 16-beat read, then a fresh read.
    clear_log();
    send_cmd(1'b0, 0, 15, lat);
    repeat (5) @(posedge clk);
    #2 rstn = 1'b0;
    #1 check("t6_strobes_in_rst", {30'b0, ram_read_en, ram_write_en}, 32'd0);
    @(posedge clk);
    #1 rstn = 1'b1;
    repeat (4) @(posedge clk);
    #1 check("t6_no_done", 32'(done_cnt), 32'd0);
    check("t6_issued_before_rst", 32'(strobe_cnt), 32'd5);
    clear_log();
    send_cmd(1'b0, 30, 1, lat);
    wait_idle();
    check("t6_rd_data", {rd_q[0], rd_q[1]}, 32'h00010002);
    check("t6_done_count", 32'(done_cnt), 32'd1);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
